trap_report_collector: RTL and testbench
========================================

# trap_report_collector

Parametrised trap collector for NoC systems with any node count. It generalises the hard-wired OR of per-node trap lines into sticky per-node trap flags and a first-trap record. Each newly trapping node gets a cycle timestamp and a serialised ASCII report (`T<id>@<time>\n`), which is pushed into the debugger ring buffer through a valid/busy character handshake. The block sits in the system top between the node `trap` outputs and the debug character stream.

## Interface
Parameters:
- `NUM_NODES`, 4: number of monitored trap lines; 1..256.
- `CNT_WIDTH`, 32: cycle-counter width; multiple of 4, 8..64.
- `ASCII_WIDTH`, 7: character width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `res`  in  1  reset; synchronous, active-high.
- `trap_in`  in  NUM_NODES  per-node trap levels.
- `clear`  in  1  one-cycle pulse; clears sticky state.
- `ascii_c`  out  ASCII_WIDTH  report character.
- `ascii_s`  out  1  character valid.
- `ascii_busy`  in  1  sink busy; a character transfers when `ascii_s && !ascii_busy`.
- `trap_mask`  out  NUM_NODES  sticky per-node trap flags.
- `trap_any`  out  1  OR of `trap_mask`.
- `trap_all`  out  1  AND of `trap_mask`.
- `first_id`  out  8  index of the first node to trap.
- `first_valid`  out  1  `first_id` holds a valid index.

## Operation
- **Cycle counter:** free-running counter, +1 per cycle from 0 after reset; wraps modulo 2^CNT_WIDTH.
- **Trap detection:** `trap_in` is registered into `trap_q`. A new trap is `trap_in & ~trap_q` (rising edge). A level held high never re-triggers, including after `clear`.
- **On a new trap for node i:**
  - Set `trap_mask[i]` and `pend[i]`.
  - Latch the counter value sampled in the same cycle into `ts[i]`.
  - If `first_valid` is 0: set `first_valid` and load `first_id` with the lowest new index.
- **Reporter state machine:** IDLE, HDR, IDH, IDL, AT, TS, NL.
  - **IDLE:** if any `pend` bit is set, choose the lowest index; store `sel` and `ts[sel]` in a shadow register; go to HDR.
  - **Per-state characters:**
    - HDR sends 'T' (0x54).
    - IDH and IDL send `sel[7:4]` and `sel[3:0]` as hex.
    - AT sends '@' (0x40).
    - TS sends CNT_WIDTH/4 digits, MSB first, using a digit counter.
    - NL sends 0x0A, clears `pend[sel]`, and returns to IDLE.
  - **Hex encoding:** uppercase; 0-9 map to 0x30-0x39, A-F to 0x41-0x46.
- **Handshake:**
  - `ascii_s` stays high in every non-IDLE state.
  - `ascii_c` stays stable until the transfer completes; the state advances only on transfer.
  - `ascii_busy` may stall any character indefinitely. No character is dropped or duplicated.
- **`clear`:**
  - Zeroes `trap_mask`, `first_valid`, `first_id` and all `pend` bits except `pend[sel]` while a message is in flight; the in-flight message completes.
  - A new trap on node i in the same cycle as `clear` wins: `trap_mask[i]` and `pend[i]` end up set.
- **Re-trap:** a re-trap of node i while `pend[i]` is already set overwrites `ts[i]`. Only one report is produced.

## Timing
- **Reset values:**
  - Zero: `ascii_c`, `ascii_s`, `trap_mask`, `trap_any`, `first_id`, `first_valid`, counter, `trap_q`, `pend`.
  - `trap_all` = 0 for any NUM_NODES.
  - The state machine resets to IDLE.
- **Status latency:** `trap_in` sampled high at edge k (with `trap_q` = 0) → `trap_mask`, `trap_any` and `first_*` update after edge k.
- **Report latency:** with the state machine idle and busy low, `ascii_s` rises after edge k+2.
- **Message length:** 5 + CNT_WIDTH/4 characters, one per cycle when busy is low, followed by one IDLE cycle before the next message.
- **Reset mid-message:** `res` high at any edge clears everything at that edge; `ascii_s` is 0 in the following cycle and pending reports are discarded.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: `NUM_NODES` = 4, `CNT_WIDTH` = 16.

1. **Single trap:** pulse `trap_in[2]` at counter 0x0010 with busy low → characters 0x54 0x30 0x32 0x40 0x30 0x30 0x31 0x30 0x0A on 9 consecutive cycles. Afterwards `trap_mask` = 0100, `trap_any` = 1, `first_id` = 2.
2. **Simultaneous traps:** raise `trap_in[3]` and `trap_in[1]` in the same cycle at counter 0x0020 → the node 1 message "T01@0020\n" is sent first, one IDLE cycle, then "T03@0020\n". `first_id` = 1; `trap_all` stays 0 until nodes 0 and 2 also trap.
3. **Backpressure:** hold `ascii_busy` high for 5 cycles during the IDL character → `ascii_c` stays 0x31 (or the current digit) and `ascii_s` stays 1. The full 9-character message is received exactly once.
4. **Clear mid-message:** pulse `clear` during the node 1 message with node 3 pending → the node 1 message completes and node 3 is never reported. Afterwards `trap_mask` = 0, `first_valid` = 0. A new rising edge on `trap_in[3]` is reported with the new timestamp.
5. **Counter wrap:** trap sampled at counter 0xFFFF → report "T00@FFFF\n". A trap on the next cycle reports "@0000".
6. **Reset mid-message:** assert `res` for one cycle at the 4th character → `ascii_s` = 0 the next cycle, all status outputs are 0, and no further characters are sent.

Source files
------------

// File: rtl/trap_report_collector.sv
// Trap report collector: sticky per-node trap flags, a first-trap record and a serialised
// ASCII report "T<id>@<time>\n" per newly trapping node, sent over a valid/busy char stream.
module trap_report_collector #(
    parameter int unsigned NUM_NODES   = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned ASCII_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [NUM_NODES-1:0]   trap_in,
    input  logic                   clear,
    output logic [ASCII_WIDTH-1:0] ascii_c,
    output logic                   ascii_s,
    input  logic                   ascii_busy,
    output logic [NUM_NODES-1:0]   trap_mask,
    output logic                   trap_any,
    output logic                   trap_all,
    output logic [7:0]             first_id,
    output logic                   first_valid
);

    localparam int unsigned NumDigits = CNT_WIDTH / 4;
    localparam int unsigned DigitW    = $clog2(NumDigits);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHdr  = 3'd1;
    localparam logic [2:0] StIdh  = 3'd2;
    localparam logic [2:0] StIdl  = 3'd3;
    localparam logic [2:0] StAt   = 3'd4;
    localparam logic [2:0] StTs   = 3'd5;
    localparam logic [2:0] StNl   = 3'd6;

    function automatic logic [6:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (7'h30 + {3'b000, n}) : (7'h37 + {3'b000, n});
    endfunction

    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [NUM_NODES-1:0]   trap_q;
    logic [NUM_NODES-1:0]   hit_q;
    logic [NUM_NODES-1:0]   new_trap;
    logic [CNT_WIDTH-1:0]   ts_q [NUM_NODES];

    logic [NUM_NODES-1:0]   trap_mask_q, trap_mask_d;
    logic                   trap_any_q, trap_all_q;
    logic [7:0]             first_id_q, first_id_d;
    logic                   first_valid_q, first_valid_d;
    logic [7:0]             new_id;

    logic [NUM_NODES-1:0]   pend_q, pend_d;
    logic [NUM_NODES-1:0]   pick_mask, sel_oh;
    logic                   pick_any;
    logic [7:0]             pick_id;
    logic [CNT_WIDTH-1:0]   pick_ts;

    logic [2:0]             state_q, state_d;
    logic [7:0]             sel_q, sel_d;
    logic [CNT_WIDTH-1:0]   shadow_q, shadow_d;
    logic [DigitW-1:0]      digit_q, digit_d;
    logic                   xfer, nl_done;
    logic [3:0]             nib;
    logic [6:0]             char7;
    logic [ASCII_WIDTH-1:0] ascii_c_q, ascii_c_d;
    logic                   ascii_s_q, ascii_s_d;

    assign ascii_c     = ascii_c_q;
    assign ascii_s     = ascii_s_q;
    assign trap_mask   = trap_mask_q;
    assign trap_any    = trap_any_q;
    assign trap_all    = trap_all_q;
    assign first_id    = first_id_q;
    assign first_valid = first_valid_q;

    // Free-running cycle counter used for trap timestamps.
    always_ff @(posedge clk) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    // Trap level history for edge detection; hit_q marks nodes whose pend bit is one cycle old.
    always_ff @(posedge clk) begin
        if (res) begin
            trap_q <= '0;
            hit_q  <= '0;
        end else begin
            trap_q <= trap_in;
            hit_q  <= new_trap;
        end
    end

    // Timestamp capture; no reset needed since a slot is only read after a trap wrote it.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_NODES; i++) begin
            if (new_trap[i]) ts_q[i] <= cnt_q;
        end
    end

    // Sticky status next state; a trap coinciding with clear survives it.
    always_comb begin
        new_trap    = trap_in & ~trap_q;
        trap_mask_d = (clear ? '0 : trap_mask_q) | new_trap;
        new_id      = '0;
        for (int i = int'(NUM_NODES) - 1; i >= 0; i--) begin
            if (new_trap[i]) new_id = 8'(i);
        end
        first_valid_d = clear ? 1'b0 : first_valid_q;
        first_id_d    = clear ? 8'h00 : first_id_q;
        if (!first_valid_d && (|new_trap)) begin
            first_valid_d = 1'b1;
            first_id_d    = new_id;
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (res) begin
            trap_mask_q   <= '0;
            trap_any_q    <= 1'b0;
            trap_all_q    <= 1'b0;
            first_id_q    <= '0;
            first_valid_q <= 1'b0;
        end else begin
            trap_mask_q   <= trap_mask_d;
            trap_any_q    <= |trap_mask_d;
            trap_all_q    <= &trap_mask_d;
            first_id_q    <= first_id_d;
            first_valid_q <= first_valid_d;
        end
    end

    // Lowest pending node eligible for reporting; freshly set pend bits wait one cycle.
    always_comb begin
        pick_mask = pend_q & ~hit_q;
        pick_any  = |pick_mask;
        pick_id   = '0;
        pick_ts   = '0;
        for (int i = int'(NUM_NODES) - 1; i >= 0; i--) begin
            if (pick_mask[i]) begin
                pick_id = 8'(i);
                pick_ts = ts_q[i];
            end
        end
        sel_oh = '0;
        for (int unsigned i = 0; i < NUM_NODES; i++) begin
            sel_oh[i] = (sel_q == 8'(i));
        end
    end

    // Pending set: clear keeps only the in-flight node, the final newline retires it.
    always_comb begin
        pend_d = pend_q;
        if (clear) pend_d = (state_q != StIdle) ? (pend_q & sel_oh) : '0;
        pend_d = pend_d | new_trap;
        if (nl_done) pend_d = pend_d & ~sel_oh;
    end

    // Reporter state machine; every non-idle state advances only on a character transfer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        digit_d  = digit_q;
        nl_done  = 1'b0;
        xfer     = ascii_s_q && !ascii_busy;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d  = StHdr;
                    sel_d    = pick_id;
                    shadow_d = pick_ts;
                end
            end
            StHdr: if (xfer) state_d = StIdh;
            StIdh: if (xfer) state_d = StIdl;
            StIdl: if (xfer) state_d = StAt;
            StAt: begin
                if (xfer) begin
                    state_d = StTs;
                    digit_d = DigitW'(NumDigits - 1);
                end
            end
            StTs: begin
                if (xfer) begin
                    if (digit_q == '0) state_d = StNl;
                    else               digit_d = digit_q - DigitW'(1);
                end
            end
            StNl: begin
                if (xfer) begin
                    state_d = StIdle;
                    nl_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Character for the next state, so ascii_c/ascii_s come straight from flops.
    always_comb begin
        nib = '0;
        for (int unsigned d = 0; d < NumDigits; d++) begin
            if (digit_d == DigitW'(d)) nib = shadow_d[4*d +: 4];
        end
        case (state_d)
            StHdr:   char7 = 7'h54;
            StIdh:   char7 = hex_char(sel_d[7:4]);
            StIdl:   char7 = hex_char(sel_d[3:0]);
            StAt:    char7 = 7'h40;
            StTs:    char7 = hex_char(nib);
            StNl:    char7 = 7'h0A;
            default: char7 = 7'h00;
        endcase
        ascii_c_d = ASCII_WIDTH'(char7);
        ascii_s_d = (state_d != StIdle);
    end

    // Reporter and pending registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            shadow_q  <= '0;
            digit_q   <= '0;
            pend_q    <= '0;
            ascii_c_q <= '0;
            ascii_s_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            digit_q   <= digit_d;
            pend_q    <= pend_d;
            ascii_c_q <= ascii_c_d;
            ascii_s_q <= ascii_s_d;
        end
    end

endmodule

// File: tb/tb_trap_report_collector.sv
// Directed bench for trap_report_collector with 4 nodes and a 16-bit timestamp.
module tb_trap_report_collector;

    localparam int NN = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          res;
    logic          clear;
    logic          ascii_busy;
    logic [NN-1:0] trap_in;
    logic [6:0]    ascii_c;
    logic          ascii_s;
    logic [NN-1:0] trap_mask;
    logic          trap_any;
    logic          trap_all;
    logic [7:0]    first_id;
    logic          first_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [CW-1:0] tb_cnt;
    logic [6:0]    cap_c [64];
    int            cap_t [64];
    int            cap_n;
    int            stall_bad;
    int            stall_seen;
    logic [6:0]    cap_hold;

    trap_report_collector #(
        .NUM_NODES  (NN),
        .CNT_WIDTH  (CW),
        .ASCII_WIDTH(7)
    ) dut (
        .clk        (clk),
        .res        (res),
        .trap_in    (trap_in),
        .clear      (clear),
        .ascii_c    (ascii_c),
        .ascii_s    (ascii_s),
        .ascii_busy (ascii_busy),
        .trap_mask  (trap_mask),
        .trap_any   (trap_any),
        .trap_all   (trap_all),
        .first_id   (first_id),
        .first_valid(first_valid)
    );

    always #5 clk = ~clk;

    // Reference cycle count: 0 after reset, +1 per edge.
    always @(posedge clk) tb_cnt <= res ? '0 : tb_cnt + 1'b1;

    // Advance to the negedge where the counter equals v, so the next edge samples it.
    task automatic wait_cnt(input logic [CW-1:0] v);
        int found = 0;
        for (int i = 0; i < 70000 && found == 0; i++) begin
            @(negedge clk);
            if (tb_cnt == v) found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL wait_cnt: counter %h never reached, required %h", tb_cnt, v);
        end
    endtask

    // Record transferred characters; optionally stall character index stall_at for stall_len.
    task automatic capture(input int n, input int stall_at, input int stall_len, input int budget);
        int st = 0;
        cap_n = 0;
        stall_bad = 0;
        stall_seen = 0;
        for (int i = 0; i < 64; i++) cap_c[i] = 'x;
        for (int cyc = 0; cyc < budget && cap_n < n; cyc++) begin
            @(negedge clk);
            clear = 1'b0;
            if (cap_n == stall_at && st < stall_len && (st > 0 || ascii_s)) begin
                if (st == 0) cap_hold = ascii_c;
                else if (ascii_c !== cap_hold || ascii_s !== 1'b1) stall_bad++;
                ascii_busy = 1'b1;
                st++;
                stall_seen++;
            end else begin
                ascii_busy = 1'b0;
                if (ascii_s === 1'b1) begin
                    cap_c[cap_n] = ascii_c;
                    cap_t[cap_n] = cyc;
                    cap_n++;
                end
            end
        end
        ascii_busy = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; clear = 1'b0; ascii_busy = 1'b0; trap_in = '0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        n_cmp++; if (ascii_s !== 1'b0) begin n_fail++;
            $display("FAIL reset_s: got %b want 0", ascii_s); end
        n_cmp++; if (ascii_c !== 7'h00) begin n_fail++;
            $display("FAIL reset_c: got %h want 00", ascii_c); end
        n_cmp++; if ({trap_mask, trap_any, trap_all} !== 6'b0) begin n_fail++;
            $display("FAIL reset_status: got %b/%b/%b want 0000/0/0", trap_mask, trap_any,
                     trap_all); end
        n_cmp++; if ({first_valid, first_id} !== 9'h0) begin n_fail++;
            $display("FAIL reset_first: got %b/%h want 0/00", first_valid, first_id); end
    endtask

    task automatic test_single();
        string exp = "T02@0010\n";
        byte b;
        wait_cnt(16'h0010);
        trap_in = 4'b0100;
        @(negedge clk);
        trap_in = '0;
        n_cmp++; if (trap_mask !== 4'b0100 || trap_any !== 1'b1 || trap_all !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: got %b/%b/%b want 0100/1/0", trap_mask, trap_any,
                     trap_all); end
        n_cmp++; if (first_valid !== 1'b1 || first_id !== 8'd2) begin n_fail++;
            $display("FAIL single_first: got %b/%h want 1/02", first_valid, first_id); end
        n_cmp++; if (ascii_s !== 1'b0) begin n_fail++;
            $display("FAIL single_early_s: got %b want 0", ascii_s); end
        capture(9, -1, 0, 40);
        n_cmp++; if (cap_n != 9 || cap_t[0] != 1 || cap_t[8] != 9) begin n_fail++;
            $display("FAIL single_timing: got n=%0d first=%0d last=%0d want 9/1/9", cap_n,
                     cap_t[0], cap_t[8]); end
        for (int i = 0; i < 9; i++) begin
            b = exp[i];
            n_cmp++; if (cap_c[i] !== b[6:0]) begin n_fail++;
                $display("FAIL single_char%0d: got %h want %h", i, cap_c[i], b[6:0]); end
        end
        @(negedge clk);
        n_cmp++; if (ascii_s !== 1'b0) begin n_fail++;
            $display("FAIL single_idle: got %b want 0", ascii_s); end
    endtask

    task automatic test_simultaneous();
        string exp = "T01@0020\nT03@0020\n";
        string exp2 = "T00@0040\nT02@0040\n";
        byte b;
        wait_cnt(16'h001E);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++; if (trap_mask !== 4'b0000 || trap_any !== 1'b0 || first_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_pre_clear: got %b/%b/%b want 0000/0/0", trap_mask, trap_any,
                     first_valid); end
        wait_cnt(16'h0020);
        trap_in = 4'b1010;
        @(negedge clk);
        trap_in = '0;
        n_cmp++; if (first_id !== 8'd1 || first_valid !== 1'b1) begin n_fail++;
            $display("FAIL sim_first: got %b/%h want 1/01", first_valid, first_id); end
        n_cmp++; if (trap_mask !== 4'b1010 || trap_all !== 1'b0) begin n_fail++;
            $display("FAIL sim_mask: got %b/%b want 1010/0", trap_mask, trap_all); end
        capture(18, -1, 0, 60);
        n_cmp++; if (cap_n != 18 || cap_t[9] - cap_t[8] != 2) begin n_fail++;
            $display("FAIL sim_gap: got n=%0d gap=%0d want 18/2", cap_n, cap_t[9] - cap_t[8]);
        end
        for (int i = 0; i < 18; i++) begin
            b = exp[i];
            n_cmp++; if (cap_c[i] !== b[6:0]) begin n_fail++;
                $display("FAIL sim_char%0d: got %h want %h", i, cap_c[i], b[6:0]); end
        end
        wait_cnt(16'h0040);
        trap_in = 4'b0101;
        @(negedge clk);
        trap_in = '0;
        n_cmp++; if (trap_mask !== 4'b1111 || trap_all !== 1'b1 || first_id !== 8'd1) begin
            n_fail++;
            $display("FAIL sim_all: got %b/%b/%h want 1111/1/01", trap_mask, trap_all, first_id);
        end
        capture(18, -1, 0, 60);
        for (int i = 0; i < 18; i++) begin
            b = exp2[i];
            n_cmp++; if (cap_c[i] !== b[6:0]) begin n_fail++;
                $display("FAIL sim2_char%0d: got %h want %h", i, cap_c[i], b[6:0]); end
        end
    endtask

    task automatic test_backpressure();
        string exp = "T01@0060\n";
        byte b;
        int extra = 0;
        wait_cnt(16'h0060);
        trap_in = 4'b0010;
        @(negedge clk);
        trap_in = '0;
        capture(9, 2, 5, 60);
        n_cmp++; if (stall_seen != 5 || stall_bad != 0 || cap_hold !== 7'h31) begin n_fail++;
            $display("FAIL bp_stall: got seen=%0d bad=%0d hold=%h want 5/0/31", stall_seen,
                     stall_bad, cap_hold); end
        n_cmp++; if (cap_n != 9 || cap_t[8] - cap_t[0] != 13) begin n_fail++;
            $display("FAIL bp_span: got n=%0d span=%0d want 9/13", cap_n, cap_t[8] - cap_t[0]);
        end
        for (int i = 0; i < 9; i++) begin
            b = exp[i];
            n_cmp++; if (cap_c[i] !== b[6:0]) begin n_fail++;
                $display("FAIL bp_char%0d: got %h want %h", i, cap_c[i], b[6:0]); end
        end
        repeat (12) begin
            @(negedge clk);
            if (ascii_s !== 1'b0) extra++;
        end
        n_cmp++; if (extra != 0) begin n_fail++;
            $display("FAIL bp_dup: got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_clear_mid();
        string exp = "T01@0080\n";
        string exp3 = "T03@00C0\n";
        byte b;
        int extra = 0;
        logic [6:0] head [4];
        wait_cnt(16'h0080);
        trap_in = 4'b1010;
        @(negedge clk);
        trap_in = '0;
        capture(4, -1, 0, 20);
        for (int i = 0; i < 4; i++) head[i] = cap_c[i];
        clear = 1'b1;
        capture(5, -1, 0, 20);
        for (int i = 0; i < 9; i++) begin
            b = exp[i];
            n_cmp++;
            if (((i < 4) ? head[i] : cap_c[i-4]) !== b[6:0]) begin n_fail++;
                $display("FAIL clr_char%0d: got %h want %h", i,
                         (i < 4) ? head[i] : cap_c[i-4], b[6:0]); end
        end
        @(negedge clk);
        n_cmp++; if (trap_mask !== 4'b0 || trap_any !== 1'b0 || first_valid !== 1'b0 ||
                     first_id !== 8'h00) begin n_fail++;
            $display("FAIL clr_status: got %b/%b/%b/%h want 0000/0/0/00", trap_mask, trap_any,
                     first_valid, first_id); end
        repeat (20) begin
            @(negedge clk);
            if (ascii_s !== 1'b0) extra++;
        end
        n_cmp++; if (extra != 0) begin n_fail++;
            $display("FAIL clr_node3_dropped: got %0d valid cycles want 0", extra); end
        wait_cnt(16'h00C0);
        trap_in = 4'b1000;
        @(negedge clk);
        trap_in = '0;
        n_cmp++; if (first_id !== 8'd3 || first_valid !== 1'b1 || trap_mask !== 4'b1000) begin
            n_fail++;
            $display("FAIL clr_retrap: got %b/%h/%b want 1/03/1000", first_valid, first_id,
                     trap_mask); end
        capture(9, -1, 0, 40);
        for (int i = 0; i < 9; i++) begin
            b = exp3[i];
            n_cmp++; if (cap_c[i] !== b[6:0]) begin n_fail++;
                $display("FAIL clr3_char%0d: got %h want %h", i, cap_c[i], b[6:0]); end
        end
    endtask

    task automatic test_wrap();
        string exp = "T00@FFFF\nT01@0000\n";
        byte b;
        wait_cnt(16'hFFFF);
        trap_in = 4'b0001;
        @(negedge clk);
        trap_in = 4'b0010;
        @(negedge clk);
        trap_in = '0;
        capture(18, -1, 0, 60);
        n_cmp++; if (cap_n != 18) begin n_fail++;
            $display("FAIL wrap_count: got %0d want 18", cap_n); end
        for (int i = 0; i < 18; i++) begin
            b = exp[i];
            n_cmp++; if (cap_c[i] !== b[6:0]) begin n_fail++;
                $display("FAIL wrap_char%0d: got %h want %h", i, cap_c[i], b[6:0]); end
        end
    endtask

    task automatic test_reset_mid();
        int extra = 0;
        wait_cnt(16'h0040);
        trap_in = 4'b0100;
        @(negedge clk);
        trap_in = '0;
        capture(4, -1, 0, 20);
        n_cmp++; if (cap_n != 4 || cap_c[3] !== 7'h40) begin n_fail++;
            $display("FAIL rst_mid_pre: got n=%0d c=%h want 4/40", cap_n, cap_c[3]); end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        n_cmp++; if (ascii_s !== 1'b0 || ascii_c !== 7'h00) begin n_fail++;
            $display("FAIL rst_mid_stream: got %b/%h want 0/00", ascii_s, ascii_c); end
        n_cmp++; if ({trap_mask, trap_any, trap_all, first_valid, first_id} !== 15'h0) begin
            n_fail++;
            $display("FAIL rst_mid_status: got %b/%b/%b/%b/%h want all 0", trap_mask, trap_any,
                     trap_all, first_valid, first_id); end
        repeat (20) begin
            @(negedge clk);
            if (ascii_s !== 1'b0) extra++;
        end
        n_cmp++; if (extra != 0) begin n_fail++;
            $display("FAIL rst_mid_quiet: got %0d valid cycles want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_clear_mid();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
